// File: rtl/matmul_top.sv
// Blocked fixed-point matrix multiply C = A * W over internal constant ROMs.
// NUM_CORES cores each accumulate one BLOCK_SIZE x BLOCK_SIZE block of C per output beat.
module matmul_top #(
    parameter int unsigned WIDTH             = 16,
    parameter int unsigned FRAC_WIDTH        = 8,
    parameter int unsigned BLOCK_SIZE        = 2,
    parameter int unsigned CHUNK_SIZE        = 4,
    parameter int unsigned INNER_DIMENSION   = 4,
    parameter int unsigned W_OUTER_DIMENSION = 6,
    parameter int unsigned I_OUTER_DIMENSION = 8,
    parameter int unsigned ROW_SIZE_MAT_C    = I_OUTER_DIMENSION / BLOCK_SIZE,
    parameter int unsigned COL_SIZE_MAT_C    = W_OUTER_DIMENSION / BLOCK_SIZE,
    parameter int unsigned NUM_CORES         = (INNER_DIMENSION == 2754) ? 17 :
                                               (INNER_DIMENSION == 256)  ? 8  :
                                               (INNER_DIMENSION == 200)  ? 5  :
                                               (INNER_DIMENSION == 64)   ? 4  : 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  wb_ena,
    input  logic                                  in_ena,
    output logic [WIDTH*CHUNK_SIZE*NUM_CORES-1:0] out_bram,
    output logic                                  out_valid,
    output logic                                  ready,
    output logic                                  done
);

    localparam int unsigned MAX_FLAG = ROW_SIZE_MAT_C * COL_SIZE_MAT_C;
    localparam int unsigned BEATS    = (MAX_FLAG + NUM_CORES - 1) / NUM_CORES;
    localparam int unsigned KW       = (INNER_DIMENSION > 1) ? $clog2(INNER_DIMENSION) : 1;
    localparam int unsigned BW       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned ACC_W    = 2 * WIDTH + $clog2(INNER_DIMENSION + 1);
    localparam int unsigned OUT_W    = WIDTH * CHUNK_SIZE * NUM_CORES;
    localparam int unsigned NACC     = CHUNK_SIZE * NUM_CORES;

    localparam logic [KW-1:0] K_LAST    = KW'(INNER_DIMENSION - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        $signed({{(ACC_W - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        $signed({{(ACC_W - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}});

    typedef enum logic [1:0] {StIdle, StCompute, StOutput, StDone} state_e;

    state_e                  state_q, state_d;
    logic [KW-1:0]           k_q;
    logic [BW-1:0]           beat_q;
    logic signed [ACC_W-1:0] acc_q [NACC];
    logic signed [ACC_W-1:0] acc_d [NACC];
    logic [OUT_W-1:0]        out_bram_q, out_bram_d;
    logic                    out_valid_q;
    logic                    step;

    // ROM contents depend only on the row of A / column of W, not on k.
    function automatic logic [WIDTH-1:0] rom_a(input int unsigned row);
        return WIDTH'((row + 1) << FRAC_WIDTH);
    endfunction

    function automatic logic [WIDTH-1:0] rom_w(input int unsigned col);
        return WIDTH'((col + 1) << FRAC_WIDTH);
    endfunction

    function automatic logic [WIDTH-1:0] sat(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) return {1'b0, {(WIDTH - 1){1'b1}}};
        if (v < SAT_MIN) return {1'b1, {(WIDTH - 1){1'b0}}};
        return v[WIDTH-1:0];
    endfunction

    assign step = wb_ena & in_ena;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StCompute;
            StCompute: if (step && k_q == K_LAST) state_d = StOutput;
            StOutput:  state_d = (beat_q == BEAT_LAST) ? StDone : StCompute;
            // Stay one cycle past the final beat so done trails the last out_valid.
            StDone:    if (!start && !out_valid_q) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        int unsigned blk, row, col, idx;
        logic [WIDTH-1:0] a_v, w_v;
        logic signed [2*WIDTH-1:0] prod;
        blk        = 0;
        row        = 0;
        col        = 0;
        idx        = 0;
        a_v        = '0;
        w_v        = '0;
        prod       = '0;
        acc_d      = acc_q;
        out_bram_d = '0;
        for (int unsigned j = 0; j < NUM_CORES; j++) begin
            for (int unsigned e = 0; e < CHUNK_SIZE; e++) begin
                idx  = j * CHUNK_SIZE + e;
                blk  = 32'(beat_q) * NUM_CORES + j;
                row  = (blk / COL_SIZE_MAT_C) * BLOCK_SIZE + e / BLOCK_SIZE;
                col  = (blk % COL_SIZE_MAT_C) * BLOCK_SIZE + e % BLOCK_SIZE;
                a_v  = rom_a(row);
                w_v  = rom_w(col);
                prod = $signed({{WIDTH{a_v[WIDTH-1]}}, a_v} * {{WIDTH{w_v[WIDTH-1]}}, w_v});
                if (state_q == StCompute && step) begin
                    acc_d[idx] = acc_q[idx] + ACC_W'(prod >>> FRAC_WIDTH);
                end else if (state_q == StOutput) begin
                    acc_d[idx] = '0;
                end
                if (blk < MAX_FLAG) out_bram_d[idx*WIDTH +: WIDTH] = sat(acc_q[idx]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            k_q         <= '0;
            beat_q      <= '0;
            out_bram_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NACC; i++) acc_q[i] <= '0;
        end else begin
            out_valid_q <= (state_q == StOutput);
            for (int i = 0; i < NACC; i++) acc_q[i] <= acc_d[i];
            if (state_q == StCompute && step) begin
                k_q <= (k_q == K_LAST) ? '0 : k_q + KW'(1);
            end
            if (state_q == StOutput) begin
                out_bram_q <= out_bram_d;
                beat_q     <= (beat_q == BEAT_LAST) ? '0 : beat_q + BW'(1);
            end
        end
    end

    always_comb begin
        ready     = (state_q == StIdle);
        done      = (state_q == StDone) && !out_valid_q;
        out_valid = out_valid_q;
        out_bram  = out_bram_q;
    end

endmodule

// File: tb/tb_matmul_top.sv
// Scoreboard bench for matmul_top: expected beats come from an independent model of C = A * W.
module tb_matmul_top;

    localparam int OUT_W = 128;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             wb_ena;
    logic             in_ena;
    logic [OUT_W-1:0] out_bram;
    logic             out_valid;
    logic             ready;
    logic             done;

    int               checks = 0;
    int               errors = 0;
    int               cyc = 0;
    int               pulses = 0;
    int               ref_cyc = 0;
    int               p0 = 0;
    logic [OUT_W-1:0] exp_q[$];

    matmul_top dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .wb_ena    (wb_ena),
        .in_ena    (in_ena),
        .out_bram  (out_bram),
        .out_valid (out_valid),
        .ready     (ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (out_valid) pulses <= pulses + 1;
    end

    task automatic check_eq(input string tag, input logic [OUT_W-1:0] got,
                            input logic [OUT_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] model_beat(input int n);
        logic [OUT_W-1:0] v;
        logic [15:0]      s;
        longint           acc;
        int               b, r, c;
        v = '0;
        for (int j = 0; j < 2; j++) begin
            b = n * 2 + j;
            if (b < 12) begin
                for (int e = 0; e < 4; e++) begin
                    r   = (b / 3) * 2 + e / 2;
                    c   = (b % 3) * 2 + e % 2;
                    acc = 0;
                    for (int k = 0; k < 4; k++) begin
                        acc += ((longint'(r + 1) * 256) * (longint'(c + 1) * 256)) >>> 8;
                    end
                    if (acc > 32767)       s = 16'h7FFF;
                    else if (acc < -32768) s = 16'h8000;
                    else                   s = 16'(acc);
                    v[(j*4+e)*16 +: 16] = s;
                end
            end
        end
        return v;
    endfunction

    task automatic push_run();
        for (int n = 0; n < 6; n++) exp_q.push_back(model_beat(n));
    endtask

    // Waits (bounded) for the next out_valid, then checks its spacing and pops the scoreboard.
    task automatic wait_beat(input string tag, input int exp_lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
        if (!out_valid) begin
            check_eq({tag, "_timeout"}, OUT_W'(0), OUT_W'(1));
            return;
        end
        check_eq({tag, "_lat"}, OUT_W'(cyc - ref_cyc), OUT_W'(exp_lat));
        ref_cyc = cyc;
        if (exp_q.size() == 0) check_eq({tag, "_extra"}, OUT_W'(1), OUT_W'(0));
        else                   check_eq({tag, "_data"}, out_bram, exp_q.pop_front());
    endtask

    initial begin
        rst_n  = 1'b1;
        start  = 1'b0;
        wb_ena = 1'b1;
        in_ena = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rst_ready", OUT_W'(ready), OUT_W'(1));
        check_eq("rst_done", OUT_W'(done), OUT_W'(0));
        check_eq("rst_valid", OUT_W'(out_valid), OUT_W'(0));
        check_eq("rst_bram", out_bram, '0);
        rst_n = 1'b0;
        @(negedge clk);

        // Run 1: free-running, start held high through DONE.
        start   = 1'b1;
        ref_cyc = cyc + 1;
        p0      = pulses;
        push_run();
        wait_beat("b0", 5);
        check_eq("b0_c00", OUT_W'(out_bram[15:0]), OUT_W'(16'h0400));
        check_eq("b0_c11", OUT_W'(out_bram[63:48]), OUT_W'(16'h1000));
        check_eq("b0_c02", OUT_W'(out_bram[79:64]), OUT_W'(16'h0C00));
        check_eq("b0_c13", OUT_W'(out_bram[127:112]), OUT_W'(16'h2000));
        for (int n = 1; n < 6; n++) wait_beat($sformatf("b%0d", n), 5);
        check_eq("last_sat", OUT_W'(out_bram[127:112]), OUT_W'(16'h7FFF));
        check_eq("done_late", OUT_W'(done), OUT_W'(0));
        @(negedge clk);
        check_eq("done_rise", OUT_W'(done), OUT_W'(1));
        check_eq("valid_fall", OUT_W'(out_valid), OUT_W'(0));
        repeat (10) @(negedge clk);
        check_eq("done_hold", OUT_W'(done), OUT_W'(1));
        check_eq("no_restart", OUT_W'(ready), OUT_W'(0));
        check_eq("pulse_cnt", OUT_W'(pulses - p0), OUT_W'(6));
        check_eq("bram_hold", out_bram, model_beat(5));
        start = 1'b0;
        @(negedge clk);
        check_eq("back_idle", OUT_W'(ready), OUT_W'(1));

        // Run 2: stalls on each enable, plus a stray start mid-run.
        start   = 1'b1;
        ref_cyc = cyc + 1;
        push_run();
        @(negedge clk);
        start = 1'b0;
        wait_beat("s0", 5);
        @(negedge clk);
        wb_ena = 1'b0;
        repeat (3) @(negedge clk);
        wb_ena = 1'b1;
        wait_beat("s1", 8);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_beat("s2", 5);
        repeat (2) @(negedge clk);
        in_ena = 1'b0;
        repeat (2) @(negedge clk);
        in_ena = 1'b1;
        wait_beat("s3", 7);
        wait_beat("s4", 5);
        wait_beat("s5", 5);
        @(negedge clk);
        check_eq("s_done", OUT_W'(done), OUT_W'(1));
        @(negedge clk);
        check_eq("s_idle", OUT_W'(ready), OUT_W'(1));

        // Run 3: reset while a beat is on the outputs, then restart from block 0.
        start   = 1'b1;
        ref_cyc = cyc + 1;
        push_run();
        wait_beat("r0", 5);
        wait_beat("r1", 5);
        rst_n = 1'b1;
        #1;
        check_eq("mid_rst_bram", out_bram, '0);
        check_eq("mid_rst_valid", OUT_W'(out_valid), OUT_W'(0));
        check_eq("mid_rst_ready", OUT_W'(ready), OUT_W'(1));
        check_eq("mid_rst_done", OUT_W'(done), OUT_W'(0));
        exp_q.delete();
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        start   = 1'b1;
        ref_cyc = cyc + 1;
        push_run();
        for (int n = 0; n < 6; n++) wait_beat($sformatf("q%0d", n), 5);
        check_eq("sb_empty", OUT_W'(exp_q.size()), OUT_W'(0));
        start = 1'b0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
